stt_engine: RTL and testbench
=============================

# stt_engine

Programmable Mealy state-machine engine: next state and output come from a run-time loadable state-transition table rather than from fixed RTL. It is the parametrised successor of the fixed table-generated FSMs and generalises state count, input width and output width. Entries carry a valid bit, so partial tables are detected. It sits between a configuration master, which loads the table, and the datapath, which steps the machine one input symbol per enabled cycle.

## Interface
Parameters:
- `STATE_W`, default 2: state register width; number of states is 2**STATE_W.
- `IN_W`, default 1: input symbol width.
- `OUT_W`, default 8: output symbol width.
- `RESET_STATE`, default 0: state entered on reset and on `clr`.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: step enable; `in` is consumed on this edge.
- `in`, input, IN_W: input symbol.
- `clr`, input, 1: synchronous return to RESET_STATE; clears `err`.
- `cfg_we`, input, 1: table write strobe.
- `cfg_addr`, input, STATE_W+IN_W: entry index, formed as {state, in}.
- `cfg_next`, input, STATE_W: next-state field written to the entry.
- `cfg_out`, input, OUT_W: output field written to the entry.
- `cfg_valid`, input, 1: valid bit written to the entry.
- `state`, output, STATE_W: current state.
- `out`, output, OUT_W: registered output symbol.
- `out_vld`, output, 1: pulses for one cycle after each successful step.
- `miss`, output, 1: pulses for one cycle after a step hits an invalid entry.
- `err`, output, 1: sticky miss flag.

## Operation
- The table has 2**(STATE_W+IN_W) entries. Each entry holds {valid, next, out}.
- **Reset (`rst_n` low):** `state`=RESET_STATE, `out`=0, `out_vld`=0, `miss`=0, `err`=0, and every entry's valid bit is cleared. The next/out fields of entries are not reset.
- Each edge is handled by the first matching case, in this priority order:
  - **`clr`=1:** `state`=RESET_STATE, `out`=0, `out_vld`=0, `miss`=0, `err`=0. Any `en` in the same cycle is ignored.
  - **`en`=1 and entry {state, in} is valid:** `state`←next, `out`←entry out, `out_vld`=1, `miss`=0.
  - **`en`=1 and entry {state, in} is invalid:** `state` holds, `out`←0, `out_vld`=0, `miss`=1, `err`←1.
  - **`en`=0:** `state` and `out` hold; `out_vld`=0 and `miss`=0.
- **Table write:** when `cfg_we`=1, the addressed entry is written on the edge. Writes are independent of `clr` and `en`.
- **Write and step to the same entry in one cycle:** the step uses the pre-write contents (read-before-write). The new contents take effect from the next step.
- **Out-of-range state:** none is possible; all 2**STATE_W encodings are legal states.

## Timing
- Step latency is one cycle. `in` sampled at edge N appears in `state`, `out`, `out_vld` and `miss` after edge N.
- The table read is combinational from the `state` register and `in`. There is no read pipeline, so back-to-back steps run every cycle.
- A table write is visible to a step on the following cycle.
- `rst_n` assertion takes effect immediately and asynchronously. Deassertion is synchronised externally. A reset mid-stream discards the current state and invalidates the whole table, so the table must be reloaded.

## Structure
- Shared package `stt_pkg` holds:
  - the field-packing order constant for table entries (valid, next, out, from MSB to LSB);
  - the default parameter values;
  - a function `stt_idx(state, in)` that returns the entry index.
- Sub-module `stt_table`: a register-file table with one combinational read port and one synchronous write port. Its valid bits are cleared asynchronously by `rst_n`.
- The top level holds the state and output registers, the priority logic and the flags.

## Test plan
- **Legacy 4-state table load.** Defaults; program these eight {state, in} → {next, out} entries:
  - {0,0}→{2,0}, {0,1}→{1,1}
  - {1,0}→{1,2}, {1,1}→{2,3}
  - {2,0}→{2,4}, {2,1}→{3,5}
  - {3,0}→{0,6}, {3,1}→{3,7}
  
  Then drive `in`=1,1,1,0 with `en`=1. Required result: `state`=1,2,3,0 and `out`=1,3,5,6, with `out_vld` high on each of the four cycles.
- **Invalid entry.** After reset, write only {0,1}; step with `in`=0. Required result: `miss` pulses, `err`=1, `state`=0, `out`=0. Then step with `in`=1: `state`=next, and `err` stays 1.
- **Enable low.** Assert `en`=0 for 3 cycles mid-sequence. Required result: `state` and `out` unchanged, `out_vld`=0.
- **Clear versus step.** Assert `clr` and `en` together in state 3. Required result: `state`=0, `out`=0, `err`=0, and no `out_vld` pulse.
- **Same-cycle write and step.** Rewrite {2,1} to {1,9} in the same cycle as a step from state 2 with `in`=1. Required result: the step uses the old entry (`state`=3, `out`=5). A later step from state 2 with `in`=1 gives `state`=1, `out`=9.
- **Reset mid-operation.** Pulse `rst_n` low between clock edges. Required result: all outputs go to their reset values immediately, and any subsequent step reports `miss`=1.

Source files
------------

// File: rtl/stt_pkg.sv
// Shared definitions for the programmable state-transition engine:
// default parameters, table-entry field packing and the entry index helper.
package stt_pkg;

    localparam int unsigned STT_STATE_W_DEF     = 2;
    localparam int unsigned STT_IN_W_DEF        = 1;
    localparam int unsigned STT_OUT_W_DEF       = 8;
    localparam int unsigned STT_RESET_STATE_DEF = 0;

    // Entry fields from LSB upward; the packed entry reads {valid, next, out}.
    typedef enum logic [1:0] {
        FLD_OUT   = 2'd0,
        FLD_NEXT  = 2'd1,
        FLD_VALID = 2'd2
    } stt_field_e;

    function automatic int unsigned stt_fld_lsb(input stt_field_e fld,
                                                input int unsigned state_w,
                                                input int unsigned out_w);
        case (fld)
            FLD_OUT:  return 0;
            FLD_NEXT: return out_w;
            default:  return out_w + state_w;
        endcase
    endfunction

    function automatic int unsigned stt_entry_w(input int unsigned state_w,
                                                input int unsigned out_w);
        return state_w + out_w + 1;
    endfunction

    // Table index is the concatenation {state, in}.
    function automatic logic [31:0] stt_idx(input logic [31:0] state,
                                            input logic [31:0] sym,
                                            input int unsigned in_w);
        return (state << in_w) | sym;
    endfunction

endpackage

// File: rtl/stt_table.sv
// Register-file transition table: one combinational read port, one synchronous
// write port. Only the valid bits are reset; next/out payloads are not.
module stt_table
    import stt_pkg::*;
#(
    parameter int unsigned STATE_W = STT_STATE_W_DEF,
    parameter int unsigned IN_W    = STT_IN_W_DEF,
    parameter int unsigned OUT_W   = STT_OUT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [STATE_W+IN_W-1:0]          rd_idx,
    output logic [STATE_W+OUT_W:0]           rd_entry_c,
    input  logic                             we,
    input  logic [STATE_W+IN_W-1:0]          wr_idx,
    input  logic [STATE_W+OUT_W:0]           wr_entry
);

    localparam int unsigned IDX_W     = STATE_W + IN_W;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam int unsigned DATA_W    = STATE_W + OUT_W;
    localparam int unsigned VALID_BIT = stt_fld_lsb(FLD_VALID, STATE_W, OUT_W);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Write port: only the addressed entry changes.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = wr_entry[VALID_BIT];
            data_d[wr_idx]  = wr_entry[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Read sees the registered contents, so a same-edge write is not visible yet.
    assign rd_entry_c = {valid_q[rd_idx], data_q[rd_idx]};

endmodule

// File: rtl/stt_engine.sv
// Programmable Mealy engine: steps one input symbol per enabled cycle through a
// run-time loaded transition table, flagging hits on invalid entries.
module stt_engine
    import stt_pkg::*;
#(
    parameter int unsigned STATE_W     = STT_STATE_W_DEF,
    parameter int unsigned IN_W        = STT_IN_W_DEF,
    parameter int unsigned OUT_W       = STT_OUT_W_DEF,
    parameter int unsigned RESET_STATE = STT_RESET_STATE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [IN_W-1:0]         in,
    input  logic                    clr,
    input  logic                    cfg_we,
    input  logic [STATE_W+IN_W-1:0] cfg_addr,
    input  logic [STATE_W-1:0]      cfg_next,
    input  logic [OUT_W-1:0]        cfg_out,
    input  logic                    cfg_valid,
    output logic [STATE_W-1:0]      state,
    output logic [OUT_W-1:0]        out,
    output logic                    out_vld,
    output logic                    miss,
    output logic                    err
);

    localparam int unsigned IDX_W     = STATE_W + IN_W;
    localparam int unsigned ENTRY_W   = stt_entry_w(STATE_W, OUT_W);
    localparam int unsigned OUT_LSB   = stt_fld_lsb(FLD_OUT, STATE_W, OUT_W);
    localparam int unsigned NEXT_LSB  = stt_fld_lsb(FLD_NEXT, STATE_W, OUT_W);
    localparam int unsigned VALID_BIT = stt_fld_lsb(FLD_VALID, STATE_W, OUT_W);
    localparam logic [STATE_W-1:0] RST_STATE = STATE_W'(RESET_STATE);

    logic [STATE_W-1:0] state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               miss_q, miss_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   rd_idx_c;
    logic [ENTRY_W-1:0] rd_entry_c;
    logic [ENTRY_W-1:0] wr_entry_c;
    logic               hit_c;
    logic [STATE_W-1:0] hit_next_c;
    logic [OUT_W-1:0]   hit_out_c;

    assign rd_idx_c = IDX_W'(stt_idx(32'(state_q), 32'(in), IN_W));

    always_comb begin
        wr_entry_c                      = '0;
        wr_entry_c[VALID_BIT]           = cfg_valid;
        wr_entry_c[NEXT_LSB +: STATE_W] = cfg_next;
        wr_entry_c[OUT_LSB +: OUT_W]    = cfg_out;
    end

    stt_table #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (rd_idx_c),
        .rd_entry_c (rd_entry_c),
        .we         (cfg_we),
        .wr_idx     (cfg_addr),
        .wr_entry   (wr_entry_c)
    );

    assign hit_c      = rd_entry_c[VALID_BIT];
    assign hit_next_c = rd_entry_c[NEXT_LSB +: STATE_W];
    assign hit_out_c  = rd_entry_c[OUT_LSB +: OUT_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            miss_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
        end
    end

    // Next state: clr beats a step; a step either hits a valid entry or misses.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        miss_d    = 1'b0;
        err_d     = err_q;
        if (clr) begin
            state_d = RST_STATE;
            out_d   = '0;
            err_d   = 1'b0;
        end else if (en) begin
            if (hit_c) begin
                state_d   = hit_next_c;
                out_d     = hit_out_c;
                out_vld_d = 1'b1;
            end else begin
                out_d  = '0;
                miss_d = 1'b1;
                err_d  = 1'b1;
            end
        end
    end

    // Outputs straight from the registers.
    assign state   = state_q;
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign miss    = miss_q;
    assign err     = err_q;

endmodule

// File: tb/tb_stt_engine.sv
// Self-checking bench for stt_engine: directed table vectors, corner sequences
// and a randomized run against a behavioural table model.
module tb_stt_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, cfg_we, cfg_valid;
    logic [0:0] in;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_next;
    logic [7:0] cfg_out;
    logic [1:0] state;
    logic [7:0] out;
    logic       out_vld, miss, err;

    int total = 0;
    int bad   = 0;

    // Behavioural model: table as plain arrays, machine as plain variables.
    bit       m_valid [8];
    int       m_next  [8];
    int       m_out   [8];
    int       m_state, m_oreg;
    bit       m_vld, m_miss, m_err;

    typedef struct {
        logic [2:0] addr;
        logic [1:0] nx;
        logic [7:0] o;
    } load_t;

    typedef struct {
        logic       sym;
        logic [1:0] exp_state;
        logic [7:0] exp_out;
        logic       exp_vld;
    } vec_t;

    load_t ld [8];
    vec_t  vec [4];

    stt_engine u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (in),
        .clr       (clr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_next  (cfg_next),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .state     (state),
        .out       (out),
        .out_vld   (out_vld),
        .miss      (miss),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
        m_state = 0; m_oreg = 0; m_vld = 0; m_miss = 0; m_err = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_state"},   32'(state),   32'(m_state));
        chk({tag, "_out"},     32'(out),     32'(m_oreg));
        chk({tag, "_out_vld"}, 32'(out_vld), 32'(m_vld));
        chk({tag, "_miss"},    32'(miss),    32'(m_miss));
        chk({tag, "_err"},     32'(err),     32'(m_err));
    endtask

    // One clock: drive, update model from pre-write table, apply write, compare.
    task automatic cyc(input logic e, input logic s, input logic c,
                       input logic we, input logic [2:0] a, input logic [1:0] nx,
                       input logic [7:0] o, input logic v, input string tag);
        int idx;
        @(negedge clk);
        en = e; in = s; clr = c;
        cfg_we = we; cfg_addr = a; cfg_next = nx; cfg_out = o; cfg_valid = v;
        @(posedge clk);
        idx = m_state * 2 + int'(s);
        if (c) begin
            m_state = 0; m_oreg = 0; m_vld = 0; m_miss = 0; m_err = 0;
        end else if (e) begin
            if (m_valid[idx]) begin
                m_state = m_next[idx]; m_oreg = m_out[idx]; m_vld = 1; m_miss = 0;
            end else begin
                m_oreg = 0; m_vld = 0; m_miss = 1; m_err = 1;
            end
        end else begin
            m_vld = 0; m_miss = 0;
        end
        if (we) begin
            m_valid[a] = v; m_next[a] = int'(nx); m_out[a] = int'(o);
        end
        #1;
        chk_model(tag);
    endtask

    task automatic step(input logic s, input string tag);
        cyc(1'b1, s, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] nx, input logic [7:0] o);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, a, nx, o, 1'b1, "wr");
    endtask

    task automatic do_clr();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, "clr");
    endtask

    initial begin
        ld[0] = '{3'd0, 2'd2, 8'd0}; ld[1] = '{3'd1, 2'd1, 8'd1};
        ld[2] = '{3'd2, 2'd1, 8'd2}; ld[3] = '{3'd3, 2'd2, 8'd3};
        ld[4] = '{3'd4, 2'd2, 8'd4}; ld[5] = '{3'd5, 2'd3, 8'd5};
        ld[6] = '{3'd6, 2'd0, 8'd6}; ld[7] = '{3'd7, 2'd3, 8'd7};
        vec[0] = '{1'b1, 2'd1, 8'd1, 1'b1};
        vec[1] = '{1'b1, 2'd2, 8'd3, 1'b1};
        vec[2] = '{1'b1, 2'd3, 8'd5, 1'b1};
        vec[3] = '{1'b0, 2'd0, 8'd6, 1'b1};

        rst_n = 1'b0; en = 0; in = 0; clr = 0;
        cfg_we = 0; cfg_addr = 0; cfg_next = 0; cfg_out = 0; cfg_valid = 0;
        model_reset();
        #12;
        chk("reset_state", 32'(state), 0);
        chk("reset_out", 32'(out), 0);
        chk("reset_vld", 32'(out_vld), 0);
        chk("reset_miss", 32'(miss), 0);
        chk("reset_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial table: only {0,1} valid.
        wr(3'd1, 2'd2, 8'h11);
        step(1'b0, "inv_miss");
        chk("inv_miss_pulse", 32'(miss), 1);
        chk("inv_err", 32'(err), 1);
        chk("inv_state", 32'(state), 0);
        chk("inv_out", 32'(out), 0);
        step(1'b1, "inv_hit");
        chk("inv_hit_state", 32'(state), 2);
        chk("inv_hit_out", 32'(out), 32'h11);
        chk("inv_err_sticky", 32'(err), 1);
        chk("inv_miss_drop", 32'(miss), 0);

        // Legacy 4-state table.
        do_clr();
        chk("clr_err", 32'(err), 0);
        for (int k = 0; k < 8; k++) wr(ld[k].addr, ld[k].nx, ld[k].o);
        for (int k = 0; k < 4; k++) begin
            step(vec[k].sym, "legacy");
            chk($sformatf("legacy_state_%0d", k), 32'(state), 32'(vec[k].exp_state));
            chk($sformatf("legacy_out_%0d", k), 32'(out), 32'(vec[k].exp_out));
            chk($sformatf("legacy_vld_%0d", k), 32'(out_vld), 32'(vec[k].exp_vld));
        end

        // Enable low holds state and out.
        step(1'b1, "pre_hold");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, "hold");
            chk("hold_state", 32'(state), 1);
            chk("hold_out", 32'(out), 1);
            chk("hold_vld", 32'(out_vld), 0);
        end

        // Clear wins over a step from state 3.
        step(1'b1, "to2");
        step(1'b1, "to3");
        chk("to3_state", 32'(state), 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, "clr_en");
        chk("clr_en_state", 32'(state), 0);
        chk("clr_en_out", 32'(out), 0);
        chk("clr_en_err", 32'(err), 0);
        chk("clr_en_vld", 32'(out_vld), 0);

        // Same-cycle write and step to {2,1}: old entry used first.
        step(1'b0, "to2b");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 2'd1, 8'd9, 1'b1, "rbw");
        chk("rbw_state", 32'(state), 3);
        chk("rbw_out", 32'(out), 5);
        step(1'b0, "back0");
        step(1'b0, "back2");
        step(1'b1, "rbw_new");
        chk("rbw_new_state", 32'(state), 1);
        chk("rbw_new_out", 32'(out), 9);

        // Randomized run against the model.
        for (int k = 0; k < 8; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'(k), 2'($urandom_range(0, 3)),
                8'($urandom), 1'($urandom_range(0, 3) != 0), "rload");
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 4) == 0), 3'($urandom), 2'($urandom),
                8'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
        end

        // Asynchronous reset between edges, then any step misses.
        step(1'b1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_out", 32'(out), 0);
        chk("async_rst_vld", 32'(out_vld), 0);
        chk("async_rst_miss", 32'(miss), 0);
        chk("async_rst_err", 32'(err), 0);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step(1'(s), "post_rst");
            chk("post_rst_miss", 32'(miss), 1);
            chk("post_rst_err", 32'(err), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
